// File: rtl/alu_divider_seq_pkg.sv
// Shared definitions for the sequential ALU divider: datapath width, counter width
// and the control state encoding.
package alu_divider_seq_pkg;

  localparam int ALU_W     = 16;
  localparam int ALU_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/alu_divider_seq_if.sv
// Execute-stage handshake to the divider: start/busy/done plus operands, results and flags.
interface alu_divider_seq_if
  import alu_divider_seq_pkg::*;
#(
  parameter int L = ALU_W
);

  logic                start;
  logic signed [L-1:0] dividend;
  logic signed [L-1:0] divisor;
  logic                busy;
  logic                done;
  logic signed [L-1:0] quotient;
  logic signed [L-1:0] remainder;
  logic                div_by_zero;
  logic                overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/alu_divider_seq_adder.sv
// Ripple-style full adder used as the divider's trial subtractor (A + ~B + 1);
// carry-out high means A >= B.
module alu_divider_seq_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule

// File: rtl/alu_divider_seq.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit
// per clock, sign fix-up afterwards; fixed l+2 edge latency from accept to done.
module alu_divider_seq
  import alu_divider_seq_pkg::*;
#(
  parameter int l     = ALU_W,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  alu_divider_seq_if.slave bus
);

  localparam logic [l-1:0]     ONE      = {{(l-1){1'b0}}, 1'b1};
  localparam logic [l-1:0]     MIN_NEG  = {1'b1, {(l-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(l-1);

  div_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [l-1:0]        r_rem, r_quo, r_dabs;
  logic signed [l-1:0] r_dvd;
  logic                r_neg_q, r_neg_r, r_zero, r_ovf_case;
  logic                r_busy, r_done, r_dbz, r_ovf;
  logic [l-1:0]        r_q, r_r;

  logic [l:0]          w_rem_sh;
  logic [l-1:0]        w_diff;
  logic                w_cout, w_ge;

  function automatic logic [l-1:0] mag(input logic signed [l-1:0] v);
    logic [l-1:0] u;
    u = v;
    return u[l-1] ? (~u + ONE) : u;
  endfunction

  function automatic logic [l-1:0] cond_neg(input logic [l-1:0] v, input logic n);
    return n ? (~v + ONE) : v;
  endfunction

  // The shifted partial remainder can reach l+1 bits; its top bit alone already
  // proves it exceeds any l-bit divisor magnitude, so an l-bit subtractor suffices.
  assign w_rem_sh = {r_rem, r_quo[l-1]};

  alu_divider_seq_adder #(.W(l)) u_trial (
    .i_a    (w_rem_sh[l-1:0]),
    .i_b    (~r_dabs),
    .i_cin  (1'b1),
    .o_sum  (w_diff),
    .o_cout (w_cout)
  );

  assign w_ge = w_rem_sh[l] | w_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy is still high in the done cycle, which blocks a start there
          if (r_done) begin
            r_busy <= 1'b0;
          end else if (!r_busy && bus.start) begin
            r_dvd      <= bus.dividend;
            r_quo      <= mag(bus.dividend);
            r_dabs     <= mag(bus.divisor);
            r_neg_q    <= bus.dividend[l-1] ^ bus.divisor[l-1];
            r_neg_r    <= bus.dividend[l-1];
            r_zero     <= (bus.divisor == '0);
            r_ovf_case <= (bus.dividend == MIN_NEG) && (bus.divisor == '1);
            r_rem      <= '0;
            r_cnt      <= CNT_LAST;
            r_busy     <= 1'b1;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff : w_rem_sh[l-1:0];
          r_quo <= {r_quo[l-2:0], w_ge};
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          if (r_zero) begin
            r_q   <= '1;
            r_r   <= r_dvd;
            r_dbz <= 1'b1;
            r_ovf <= 1'b0;
          end else begin
            r_q   <= cond_neg(r_quo, r_neg_q);
            r_r   <= cond_neg(r_rem, r_neg_r);
            r_dbz <= 1'b0;
            r_ovf <= r_ovf_case;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Bench for alu_divider_seq: directed literal vectors plus random pairs, with a
// cycle-timed reference model compared against every DUT output each cycle.
module tb_alu_divider_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  alu_divider_seq_if #(.L(16)) bus ();

  alu_divider_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from plain signed arithmetic plus the two special cases.
  function automatic void ref_div(input logic signed [15:0] a, input logic signed [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
    int ia;
    int ib;
    ia = a;
    ib = b;
    dz = 1'b0;
    ov = 1'b0;
    if (ib == 0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else if (ia == -32768 && ib == -1) begin
      q = 16'h8000; r = 16'h0000; ov = 1'b1;
    end else begin
      q = 16'(ia / ib);
      r = 16'(ia % ib);
    end
  endfunction

  // Timing model: accept at edge A, outputs load at A+17, done at A+18, busy drops at A+19.
  int          edge_n = 0;
  int          m_acc  = 0;
  logic        m_valid = 1'b0;
  logic        m_act = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_dbz = 1'b0, m_ovf = 1'b0, p_dbz = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin
    logic was_busy;
    edge_n++;
    was_busy = m_busy;
    if (rst) begin
      m_valid = 1'b1;
      m_act = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_act && edge_n == m_acc + 17) begin
        m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
      end
      if (m_act && edge_n == m_acc + 18) m_done = 1'b1;
      if (m_act && edge_n == m_acc + 19) begin
        m_act = 1'b0; m_busy = 1'b0;
      end
      if (!was_busy && bus.start) begin
        m_acc = edge_n; m_act = 1'b1; m_busy = 1'b1;
        ref_div(bus.dividend, bus.divisor, p_q, p_r, p_dbz, p_ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {15'd0, bus.busy}, {15'd0, m_busy});
      chk("done", {15'd0, bus.done}, {15'd0, m_done});
      chk("quotient", bus.quotient, m_q);
      chk("remainder", bus.remainder, m_r);
      chk("div_by_zero", {15'd0, bus.div_by_zero}, {15'd0, m_dbz});
      chk("overflow", {15'd0, bus.overflow}, {15'd0, m_ovf});
    end
  end

  task automatic run_op(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ed, input logic eo, input string nm);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = ~a; bus.divisor = ~b;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 16'(n), 16'd18);
    chk({nm, "_q"}, bus.quotient, eq);
    chk({nm, "_r"}, bus.remainder, er);
    chk({nm, "_dbz"}, {15'd0, bus.div_by_zero}, {15'd0, ed});
    chk({nm, "_ovf"}, {15'd0, bus.overflow}, {15'd0, eo});
  endtask

  initial begin
    logic signed [15:0] a, b;
    logic [15:0]        q, r;
    logic               dz, ov;
    int                 dones;

    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {15'd0, bus.busy}, 16'd0);
    chk("reset_done", {15'd0, bus.done}, 16'd0);
    chk("reset_q", bus.quotient, 16'd0);
    chk("reset_r", bus.remainder, 16'd0);
    chk("reset_flags", {14'd0, bus.div_by_zero, bus.overflow}, 16'd0);
    rst = 1'b0;

    run_op(16'sd100, 16'sd7, 16'd14, 16'd2, 1'b0, 1'b0, "basic");
    run_op(-16'sd100, 16'sd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, "neg_dvd");
    run_op(16'sd100, -16'sd7, 16'hFFF2, 16'd2, 1'b0, 1'b0, "neg_dvs");
    run_op(-16'sd100, -16'sd7, 16'd14, 16'hFFFE, 1'b0, 1'b0, "neg_both");
    run_op(16'sh1234, 16'sh0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, "div_zero");
    run_op(16'sh8000, 16'shFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, "overflow");
    run_op(16'sh8000, 16'sd1, 16'h8000, 16'h0000, 1'b0, 1'b0, "min_by_one");
    run_op(16'sh8000, 16'sh0000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, "min_by_zero");

    // Extra start pulses mid-operation and in the done cycle must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'sd1000; bus.divisor = -16'sd3;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      bus.start = (k == 3 || k == 18 || k == 19);
      bus.dividend = -16'sd5; bus.divisor = 16'sd2;
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        chk("hs_latency", 16'(k), 16'd18);
      end
    end
    bus.start = 1'b0;
    chk("hs_done_count", 16'(dones), 16'd1);
    chk("hs_hold_q", bus.quotient, 16'hFEB3);
    chk("hs_hold_r", bus.remainder, 16'd1);

    // Reset in the middle of CALC aborts with outputs cleared and no done.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'sd30000; bus.divisor = 16'sd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {15'd0, bus.busy}, 16'd0);
    chk("midrst_q", bus.quotient, 16'd0);
    chk("midrst_r", bus.remainder, 16'd0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", 16'(dones), 16'd0);
    run_op(16'sd32767, 16'sd1, 16'h7FFF, 16'h0000, 1'b0, 1'b0, "after_rst");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 16'sd9; bus.divisor = 16'sd2;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_prio_busy", {15'd0, bus.busy}, 16'd0);
    @(negedge clk);
    chk("rst_prio_busy2", {15'd0, bus.busy}, 16'd0);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      if (i % 4 == 0) begin
        b = 16'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else begin
        b = 16'($urandom);
      end
      if (b == 16'sd0) b = 16'sd1;
      if (i % 50 == 7) a = 16'sh8000;
      ref_div(a, b, q, r, dz, ov);
      run_op(a, b, q, r, dz, ov, "rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
